// File: rtl/ramio_port_arbiter.sv
// Two-requester round-robin arbiter for the RAMIO data port (port A).
// One command is latched per transaction; a watchdog aborts transactions that never complete.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | arbitrate; grant latches the command (null ops finish here)
// ISSUE  | m_en high with the latched command until m_bsy drops
// WAIT   | command accepted; wait for m_valid (read) or !m_bsy (write)
module ramio_port_arbiter #(
   parameter int TIMEOUT_CYCLES   = 1024,
   parameter int TIMEOUT_BITWIDTH = 16
) (
   input  logic        clk_cpu,
   input  logic        rst,
   input  logic        r0_req,
   input  logic [2:0]  r0_re,
   input  logic [1:0]  r0_we,
   input  logic [31:0] r0_addr,
   input  logic [31:0] r0_din,
   output logic [31:0] r0_dout,
   output logic        r0_done,
   output logic        r0_err,
   input  logic        r1_req,
   input  logic [2:0]  r1_re,
   input  logic [1:0]  r1_we,
   input  logic [31:0] r1_addr,
   input  logic [31:0] r1_din,
   output logic [31:0] r1_dout,
   output logic        r1_done,
   output logic        r1_err,
   output logic        m_en,
   output logic [2:0]  m_re,
   output logic [1:0]  m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_din,
   input  logic [31:0] m_dout,
   input  logic        m_valid,
   input  logic        m_bsy,
   output logic        owner,
   output logic        busy
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   localparam logic [TIMEOUT_BITWIDTH-1:0] LP_WD_LAST = TIMEOUT_BITWIDTH'(TIMEOUT_CYCLES - 1);

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [2:0]                  r_re;
   logic [1:0]                  r_we;
   logic [31:0]                 r_addr;
   logic [31:0]                 r_din;
   logic                        r_owner;
   logic                        r_last_owner;
   logic [TIMEOUT_BITWIDTH-1:0] r_wd;
   logic [31:0]                 r_dout0;
   logic [31:0]                 r_dout1;
   logic                        r_done0;
   logic                        r_done1;
   logic                        r_err0;
   logic                        r_err1;

   logic        w_elig0;
   logic        w_elig1;
   logic        w_grant;
   logic        w_grant_id;
   logic [2:0]  w_sel_re;
   logic [1:0]  w_sel_we;
   logic [31:0] w_sel_addr;
   logic [31:0] w_sel_din;
   logic        w_null;
   logic        w_is_write;
   logic        w_wd_hit;
   logic        w_complete;
   logic        w_timeout;

   // a requester showing done this cycle is masked so a stale req is not re-granted
   assign w_elig0    = r0_req & ~r_done0;
   assign w_elig1    = r1_req & ~r_done1;
   assign w_grant_id = (w_elig0 & w_elig1) ? ~r_last_owner : w_elig1;
   assign w_sel_re   = w_grant_id ? r1_re   : r0_re;
   assign w_sel_we   = w_grant_id ? r1_we   : r0_we;
   assign w_sel_addr = w_grant_id ? r1_addr : r0_addr;
   assign w_sel_din  = w_grant_id ? r1_din  : r0_din;
   assign w_null     = (w_sel_re == 3'b000) && (w_sel_we == 2'b00);
   assign w_is_write = (r_we != 2'b00);
   assign w_wd_hit   = (r_wd == LP_WD_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_complete  = 1'b0;
      w_timeout   = 1'b0;
      m_en        = 1'b0;
      m_re        = 3'b000;
      m_we        = 2'b00;
      m_addr      = 32'h0;
      m_din       = 32'h0;
      case (r_state)
         S_IDLE: begin
            if (w_elig0 | w_elig1) begin
               w_grant = 1'b1;
               if (!w_null) w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            m_en   = ~w_wd_hit;
            m_re   = w_is_write ? 3'b000 : r_re;
            m_we   = w_wd_hit ? 2'b00 : r_we;
            m_addr = r_addr;
            m_din  = r_din;
            if (w_wd_hit) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (!m_bsy) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            m_re       = w_is_write ? 3'b000 : r_re;
            m_addr     = r_addr;
            m_din      = r_din;
            w_complete = w_is_write ? ~m_bsy : m_valid;
            if (w_complete) begin
               w_state_nxt = S_IDLE;
            end else if (w_wd_hit) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_cpu) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_re         <= 3'b000;
         r_we         <= 2'b00;
         r_addr       <= 32'h0;
         r_din        <= 32'h0;
         r_owner      <= 1'b0;
         r_last_owner <= 1'b1;
         r_wd         <= '0;
         r_dout0      <= 32'h0;
         r_dout1      <= 32'h0;
         r_done0      <= 1'b0;
         r_done1      <= 1'b0;
         r_err0       <= 1'b0;
         r_err1       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         r_err0  <= 1'b0;
         r_err1  <= 1'b0;
         if (w_grant) begin
            r_re         <= w_sel_re;
            r_we         <= w_sel_we;
            r_addr       <= w_sel_addr;
            r_din        <= w_sel_din;
            r_owner      <= w_grant_id;
            r_last_owner <= w_grant_id;
            r_wd         <= '0;
            if (w_null) begin
               if (w_grant_id) r_done1 <= 1'b1;
               else            r_done0 <= 1'b1;
            end
         end else if (r_state != S_IDLE) begin
            r_wd <= r_wd + 1'b1;
         end
         if (w_complete | w_timeout) begin
            if (r_owner) begin
               r_done1 <= 1'b1;
               r_err1  <= w_timeout;
               if (w_timeout)        r_dout1 <= 32'h0;
               else if (!w_is_write) r_dout1 <= m_dout;
            end else begin
               r_done0 <= 1'b1;
               r_err0  <= w_timeout;
               if (w_timeout)        r_dout0 <= 32'h0;
               else if (!w_is_write) r_dout0 <= m_dout;
            end
         end
      end
   end

   assign r0_dout = r_dout0;
   assign r1_dout = r_dout1;
   assign r0_done = r_done0;
   assign r1_done = r_done1;
   assign r0_err  = r_err0;
   assign r1_err  = r_err1;
   assign owner   = r_owner;
   assign busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_ramio_port_arbiter.sv
// Bench for ramio_port_arbiter: a RAMIO slave model, directed scenarios, then randomized
// traffic from both requesters; a monitor pops expected responses on every done pulse.
module tb_ramio_port_arbiter;
   localparam int TO     = 8;
   localparam int NRAND  = 40;

   logic        clk_cpu = 1'b0;
   logic        rst;
   logic        req     [2];
   logic [2:0]  re_a    [2];
   logic [1:0]  we_a    [2];
   logic [31:0] addr_a  [2];
   logic [31:0] din_a   [2];
   logic [31:0] r0_dout, r1_dout;
   logic        r0_done, r1_done, r0_err, r1_err;
   logic        m_en;
   logic [2:0]  m_re;
   logic [1:0]  m_we;
   logic [31:0] m_addr, m_din, m_dout;
   logic        m_valid, m_bsy;
   logic        owner, busy;

   typedef struct {
      logic [31:0] dout;
      logic        err;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] last_dout [2];
   int          total = 0;
   int          bad   = 0;
   bit          chk_alt = 0;
   int          s_force_stall = 0;
   int          s_force_delay = 0;
   bit          s_never = 0;

   always #5 clk_cpu = ~clk_cpu;

   ramio_port_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_BITWIDTH(16)) dut (
      .clk_cpu(clk_cpu), .rst(rst),
      .r0_req(req[0]), .r0_re(re_a[0]), .r0_we(we_a[0]), .r0_addr(addr_a[0]), .r0_din(din_a[0]),
      .r0_dout(r0_dout), .r0_done(r0_done), .r0_err(r0_err),
      .r1_req(req[1]), .r1_re(re_a[1]), .r1_we(we_a[1]), .r1_addr(addr_a[1]), .r1_din(din_a[1]),
      .r1_dout(r1_dout), .r1_done(r1_done), .r1_err(r1_err),
      .m_en(m_en), .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_din(m_din),
      .m_dout(m_dout), .m_valid(m_valid), .m_bsy(m_bsy),
      .owner(owner), .busy(busy)
   );

   function automatic logic [31:0] data_of(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
   endfunction

   function automatic logic done_of(input int i);
      return (i == 0) ? r0_done : r1_done;
   endfunction

   function automatic logic err_of(input int i);
      return (i == 0) ? r0_err : r1_err;
   endfunction

   function automatic logic [31:0] dout_of(input int i);
      return (i == 0) ? r0_dout : r1_dout;
   endfunction

   // reads return memory data; writes and null ops leave the requester's dout unchanged
   function automatic logic [31:0] exp_rd(input int i, input logic [2:0] r, input logic [1:0] w,
                                          input logic [31:0] a);
      if (w != 2'b00 || r == 3'b000) return last_dout[i];
      return data_of(a);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic push(input int i, input logic [31:0] d, input logic e);
      exp_t x;
      x.dout = d;
      x.err  = e;
      if (i == 0) q0.push_back(x);
      else        q1.push_back(x);
      last_dout[i] = d;
   endtask

   task automatic check_reset(input string nm);
      chk({nm, "_m_en"}, m_en, 0);
      chk({nm, "_m_re"}, m_re, 0);
      chk({nm, "_m_we"}, m_we, 0);
      chk({nm, "_m_addr"}, m_addr, 0);
      chk({nm, "_m_din"}, m_din, 0);
      chk({nm, "_done"}, {r0_done, r1_done, r0_err, r1_err}, 0);
      chk({nm, "_r0_dout"}, r0_dout, 0);
      chk({nm, "_r1_dout"}, r1_dout, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_owner"}, owner, 0);
   endtask

   task automatic do_reset(input string nm);
      rst = 1'b1;
      req[0] = 1'b0;
      req[1] = 1'b0;
      q0.delete();
      q1.delete();
      last_dout[0] = 32'h0;
      last_dout[1] = 32'h0;
      repeat (2) @(negedge clk_cpu);
      check_reset(nm);
      rst = 1'b0;
      @(negedge clk_cpu);
   endtask

   // single transaction on requester i; returns cycles to done, m_en cycles, other-side dones
   task automatic run1(input int i, input logic [2:0] r, input logic [1:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] edout, input logic eerr,
                       output int lat, output int en_cyc, output int other_done);
      re_a[i] = r; we_a[i] = w; addr_a[i] = a; din_a[i] = d;
      push(i, edout, eerr);
      req[i] = 1'b1;
      lat = 0; en_cyc = 0; other_done = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk_cpu);
         if (m_en) en_cyc++;
         if (done_of(1 - i)) other_done++;
         if (done_of(i)) begin
            lat = k;
            break;
         end
      end
      req[i] = 1'b0;
   endtask

   task automatic run_pair(output int first, output int second,
                           output logic [31:0] first_addr, output logic [1:0] first_we);
      bit seen_en;
      @(negedge clk_cpu);
      re_a[0] = 3'b000; we_a[0] = 2'b01; addr_a[0] = 32'hFFFF_FFFE; din_a[0] = 32'h41;
      re_a[1] = 3'b011; we_a[1] = 2'b00; addr_a[1] = 32'h0000_0200; din_a[1] = 32'h0;
      push(0, exp_rd(0, re_a[0], we_a[0], addr_a[0]), 1'b0);
      push(1, exp_rd(1, re_a[1], we_a[1], addr_a[1]), 1'b0);
      req[0] = 1'b1; req[1] = 1'b1;
      first = -1; second = -1; first_addr = 32'h0; first_we = 2'b00; seen_en = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk_cpu);
         if (m_en && !seen_en) begin
            seen_en = 1;
            first_addr = m_addr;
            first_we = m_we;
         end
         for (int j = 0; j < 2; j++) begin
            if (req[j] && done_of(j)) begin
               if (first < 0) first = j;
               else           second = j;
               req[j] = 1'b0;
            end
         end
         if (!req[0] && !req[1]) break;
      end
      req[0] = 1'b0; req[1] = 1'b0;
   endtask

   // RAMIO slave: optional accept stall in ISSUE, then read-data or write-busy delay in WAIT
   initial begin
      int phase;
      int cnt;
      m_bsy = 1'b0; m_valid = 1'b0; m_dout = 32'h0;
      phase = 0; cnt = 0;
      forever begin
         @(negedge clk_cpu);
         m_bsy = 1'b0;
         m_valid = 1'b0;
         m_dout = $urandom;
         if (m_en) begin
            if (phase != 1) begin
               phase = 1;
               cnt = (s_force_stall >= 0) ? s_force_stall : int'($urandom_range(0, 2));
            end
            if (cnt > 0) begin
               m_bsy = 1'b1;
               cnt--;
            end
         end else if (busy) begin
            if (phase != 2) begin
               phase = 2;
               cnt = (s_force_delay >= 0) ? s_force_delay : int'($urandom_range(0, 2));
            end
            if (s_never) begin
               if (m_re == 3'b000) m_bsy = 1'b1;
            end else if (cnt > 0) begin
               if (m_re == 3'b000) m_bsy = 1'b1;
               cnt--;
            end else if (m_re != 3'b000) begin
               m_valid = 1'b1;
               m_dout = data_of(m_addr);
            end
         end else begin
            phase = 0;
         end
      end
   end

   // monitor: scoreboard pop on done, port-A command checks every cycle
   initial begin
      int   prev;
      int   o;
      exp_t e;
      prev = -1;
      forever begin
         @(negedge clk_cpu);
         if (rst || !chk_alt) prev = -1;
         if (!rst) begin
            chk("done_both", {r0_done, r1_done} == 2'b11, 0);
            for (int i = 0; i < 2; i++) begin
               if (done_of(i)) begin
                  if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                     total++;
                     bad++;
                     $display("FAIL spurious_done r%0d actual=1 required=0", i);
                  end else begin
                     e = (i == 0) ? q0.pop_front() : q1.pop_front();
                     chk($sformatf("dout_r%0d", i), dout_of(i), e.dout);
                     chk($sformatf("err_r%0d", i), err_of(i), e.err);
                  end
                  if (prev >= 0) chk("alternate", i, 1 - prev);
                  prev = i;
               end else begin
                  chk($sformatf("err_no_done_r%0d", i), err_of(i), 0);
               end
            end
            o = int'(owner);
            if (m_en) begin
               chk("issue_busy", busy, 1);
               chk("issue_req", req[o], 1);
               chk("issue_addr", m_addr, addr_a[o]);
               chk("issue_we", m_we, we_a[o]);
               chk("issue_re", m_re, (we_a[o] != 2'b00) ? 3'b000 : re_a[o]);
               chk("issue_din", m_din, din_a[o]);
            end else if (busy) begin
               chk("wait_we", m_we, 0);
               chk("wait_addr", m_addr, addr_a[o]);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int          lat, en, od, f, s;
      int          cnt  [2];
      int          wcnt [2];
      logic [31:0] fa;
      logic [1:0]  fw;
      int          kind;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; re_a[i] = 3'b000; we_a[i] = 2'b00; addr_a[i] = 32'h0; din_a[i] = 32'h0;
         last_dout[i] = 32'h0; cnt[i] = 0; wcnt[i] = 0;
      end
      rst = 1'b1;
      @(negedge clk_cpu);
      do_reset("rst_init");

      // first read after reset: best-case latency, single m_en cycle
      run1(0, 3'b111, 2'b00, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, lat, en, od);
      chk("t1_latency", lat, 3);
      chk("t1_en_cycles", en, 1);
      chk("t1_r1_done", od, 0);
      @(negedge clk_cpu);
      chk("t1_dout_hold", r0_dout, 32'hDEAD_BEEF);

      run1(0, 3'b000, 2'b00, 32'h0000_0700, 32'h0, exp_rd(0, 3'b000, 2'b00, 32'h700), 1'b0, lat, en, od);
      chk("null_latency", lat, 1);
      chk("null_en_cycles", en, 0);

      do_reset("rst_pair");
      run_pair(f, s, fa, fw);
      chk("pair1_first", f, 0);
      chk("pair1_second", s, 1);
      chk("pair1_addr", fa, 32'hFFFF_FFFE);
      chk("pair1_we", fw, 2'b01);
      run_pair(f, s, fa, fw);
      chk("pair2_first", f, 0);
      chk("pair2_second", s, 1);

      @(negedge clk_cpu);
      s_force_stall = 5;
      run1(0, 3'b010, 2'b00, 32'h0000_0444, 32'h0, exp_rd(0, 3'b010, 2'b00, 32'h444), 1'b0, lat, en, od);
      chk("stall_en_cycles", en, 6);
      chk("stall_latency", lat, 8);
      s_force_stall = 0;

      @(negedge clk_cpu);
      s_never = 1;
      run1(1, 3'b011, 2'b00, 32'h0000_0300, 32'h0, 32'h0, 1'b1, lat, en, od);
      chk("to_latency", lat, TO + 1);
      chk("to_en_cycles", en, 1);
      s_never = 0;
      @(negedge clk_cpu);
      chk("to_idle", busy, 0);
      chk("to_dout_hold", r1_dout, 32'h0);
      run1(0, 3'b111, 2'b00, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, lat, en, od);
      chk("after_to_latency", lat, 3);

      // reset while an r0 write sits in WAIT, with r1 already requesting
      @(negedge clk_cpu);
      s_force_delay = 3;
      re_a[0] = 3'b000; we_a[0] = 2'b11; addr_a[0] = 32'h0000_0500; din_a[0] = 32'h1234_5678;
      req[0] = 1'b1;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk_cpu);
         if (busy && !m_en) begin
            lat = k;
            break;
         end
      end
      chk("rst_mid_reach_wait", lat, 2);
      rst = 1'b1;
      req[0] = 1'b0;
      re_a[1] = 3'b001; we_a[1] = 2'b00; addr_a[1] = 32'h0000_0600; din_a[1] = 32'h0;
      req[1] = 1'b1;
      q0.delete(); q1.delete();
      last_dout[0] = 32'h0; last_dout[1] = 32'h0;
      @(negedge clk_cpu);
      check_reset("rst_mid");
      rst = 1'b0;
      push(1, data_of(32'h600), 1'b0);
      @(negedge clk_cpu);
      chk("rst_rel_busy", busy, 1);
      chk("rst_rel_owner", owner, 1);
      chk("rst_rel_en", m_en, 1);
      lat = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk_cpu);
         if (r1_done) begin
            lat = k;
            break;
         end
      end
      req[1] = 1'b0;
      chk("rst_rel_r1_served", lat != 0, 1);
      chk("rst_rel_r0_dout", r0_dout, 0);

      // randomized traffic, both requesters re-requesting immediately
      @(negedge clk_cpu);
      s_force_stall = -1;
      s_force_delay = -1;
      chk_alt = 1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk_cpu);
         for (int i = 0; i < 2; i++) begin
            if (req[i]) begin
               if (done_of(i)) begin
                  req[i] = 1'b0;
               end else if (++wcnt[i] > 60) begin
                  total++;
                  bad++;
                  $display("FAIL rand_stuck r%0d actual=no_done required=done", i);
                  req[i] = 1'b0;
               end
            end else if (cnt[i] < NRAND) begin
               kind = int'($urandom_range(0, 9));
               if (kind == 0) begin
                  re_a[i] = 3'b000;
                  we_a[i] = 2'b00;
               end else if (kind <= 4) begin
                  re_a[i] = 3'($urandom_range(0, 7));
                  we_a[i] = 2'($urandom_range(1, 3));
               end else begin
                  re_a[i] = {1'($urandom_range(0, 1)), 2'($urandom_range(1, 3))};
                  we_a[i] = 2'b00;
               end
               addr_a[i] = $urandom;
               din_a[i]  = $urandom;
               push(i, exp_rd(i, re_a[i], we_a[i], addr_a[i]), 1'b0);
               req[i] = 1'b1;
               cnt[i]++;
               wcnt[i] = 0;
            end
         end
         if (cnt[0] == NRAND && cnt[1] == NRAND && !req[0] && !req[1]) break;
      end
      repeat (2) @(negedge clk_cpu);
      chk_alt = 0;
      chk("rand_q0_empty", q0.size(), 0);
      chk("rand_q1_empty", q1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
